// File: rtl/display_pkg.sv
// Shared seven-segment patterns and BCD decode helper.
// Patterns are active-high, bit 0 = segment a.
package display_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic [6:0] bcd_to_seg(
    input logic [3:0] bcd
  );
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-high seven-segment decoder.
// Non-decimal codes render as a dash.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/bcd_display_scanner.sv
// Multiplexed seven-segment scanner with double-buffered BCD row
// and optional leading-zero blanking.
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    bcd_valid,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] row_t;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  lit_q, lit_d;
  row_t                  pend_q, pend_d;
  row_t                  disp_q, disp_d;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
  logic [NUM_DIGITS-1:0] ddp_q, ddp_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  fd_q;

  logic                  tick, wrap, blank;
  logic [NUM_DIGITS-1:0] zero_up;
  logic [NUM_DIGITS-1:0] an_hi;
  logic [3:0]            sel_bcd;
  logic [6:0]            dec_seg, seg_hi;
  logic                  dp_hi;

  seg7_decoder u_dec (
    .bcd (sel_bcd),
    .seg (dec_seg)
  );

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
    // The first tick only lights digit 0; scanning advances after that.
    lit_d = lit_q | tick;
    wrap  = tick && lit_q && (idx_q == IDX_MAX);
    idx_d = idx_q;
    if (tick && lit_q) idx_d = wrap ? '0 : idx_q + IW'(1);

    pend_d = bcd_valid ? row_t'(bcd_in) : pend_q;
    pdp_d  = bcd_valid ? dp_in : pdp_q;
    disp_d = wrap ? pend_d : disp_q;
    ddp_d  = wrap ? pdp_d : ddp_q;

    zero_up = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      for (int j = i; j < NUM_DIGITS; j++) begin
        if (disp_d[j] != 4'd0) zero_up[i] = 1'b0;
      end
    end

    sel_bcd = disp_d[idx_d];
    blank   = blank_lz && (idx_d != '0) && zero_up[idx_d];
    seg_hi  = blank ? SEG_OFF : dec_seg;
    dp_hi   = ddp_d[idx_d];
    an_hi   = '0;
    an_hi[idx_d] = 1'b1;

    if (!lit_d) begin
      seg_hi = SEG_OFF;
      dp_hi  = 1'b0;
      an_hi  = '0;
    end

    seg_d = seg_hi ^ {7{ACTIVE_LOW}};
    dp_d  = dp_hi ^ ACTIVE_LOW;
    an_d  = an_hi ^ {NUM_DIGITS{ACTIVE_LOW}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      lit_q  <= 1'b0;
      pend_q <= '0;
      disp_q <= '0;
      pdp_q  <= '0;
      ddp_q  <= '0;
      seg_q  <= {7{ACTIVE_LOW}};
      dp_q   <= ACTIVE_LOW;
      an_q   <= {NUM_DIGITS{ACTIVE_LOW}};
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      lit_q  <= lit_d;
      pend_q <= pend_d;
      disp_q <= disp_d;
      pdp_q  <= pdp_d;
      ddp_q  <= ddp_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      fd_q   <= wrap;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Randomized and directed bench for bcd_display_scanner, both polarities
// side by side, against an edge-count based reference model.
module tb_bcd_display_scanner;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FR  = N * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = '0;
  logic        bcd_valid = 1'b0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;

  logic [6:0] seg_l, seg_h;
  logic       dp_l, dp_h, fd_l, fd_h;
  logic [3:0] an_l, an_h;

  always #5 clk = ~clk;

  bcd_display_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_l), .dp(dp_l),
    .an(an_l), .frame_done(fd_l)
  );

  bcd_display_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg_h), .dp(dp_h),
    .an(an_h), .frame_done(fd_h)
  );

  int checks   = 0;
  int failures = 0;
  int e        = 0;

  logic [3:0]  pend [N];
  logic [3:0]  disp [N];
  logic [3:0]  pdp, ddp;
  logic [12:0] exp_h, exp_l;
  wire  [12:0] got_h = {fd_h, seg_h, dp_h, an_h};
  wire  [12:0] got_l = {fd_l, seg_l, dp_l, an_l};

  function automatic logic [6:0] dec(input logic [3:0] v);
    logic [6:0] tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    return (v < 10) ? tbl[v] : 7'h40;
  endfunction

  function automatic bit is_wrap(input int k);
    return (k > DIV) && ((k - DIV) % FR == 0);
  endfunction

  // Model: e counts edges since reset release; digit d's slot and
  // frame boundaries follow directly from e.
  task automatic step();
    int  d;
    bit  blank;
    logic [6:0] s;
    @(posedge clk);
    if (rst) begin
      e = 0;
      for (int i = 0; i < N; i++) begin
        pend[i] = '0;
        disp[i] = '0;
      end
      pdp   = '0;
      ddp   = '0;
      exp_h = '0;
    end else begin
      e++;
      if (bcd_valid) begin
        for (int i = 0; i < N; i++) pend[i] = bcd_in[4*i +: 4];
        pdp = dp_in;
      end
      if (is_wrap(e)) begin
        disp = pend;
        ddp  = pdp;
      end
      if (e < DIV) begin
        exp_h = '0;
      end else begin
        d = ((e - DIV) / DIV) % N;
        blank = blank_lz && (d != 0);
        for (int j = d; j < N; j++) if (disp[j] != 0) blank = 0;
        s = blank ? 7'h00 : dec(disp[d]);
        exp_h = {is_wrap(e), s, ddp[d], 4'(1 << d)};
      end
    end
    exp_l = {exp_h[12], ~exp_h[11:0]};
    #1;
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < FR; i++) begin
      if (e > DIV && (e - DIV) % FR == phase) break;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (got_h !== exp_h || got_l !== exp_l) begin
        failures++;
        $display("FAIL reset e=%0d hi=%h/%h lo=%h/%h",
                 e, got_h, exp_h, got_l, exp_l);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 2 * FR + DIV; i++) begin
      step();
      checks++;
      if (got_h !== exp_h || got_l !== exp_l) begin
        failures++;
        $display("FAIL scan e=%0d hi=%h/%h lo=%h/%h",
                 e, got_h, exp_h, got_l, exp_l);
      end
      if (e == DIV || e == 2 * DIV) begin
        checks++;
        if (an_l !== ((e == DIV) ? 4'hE : 4'hD)) begin
          failures++;
          $display("FAIL first_an e=%0d an=%h", e, an_l);
        end
      end
    end
  endtask

  task automatic test_capture();
    run_to(6);
    bcd_in = 16'h1234;
    dp_in  = 4'($urandom);
    bcd_valid = 1'b1;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      bcd_valid = 1'b0;
      checks++;
      if (got_h !== exp_h || got_l !== exp_l) begin
        failures++;
        $display("FAIL capture e=%0d hi=%h/%h lo=%h/%h",
                 e, got_h, exp_h, got_l, exp_l);
      end
    end
  endtask

  task automatic test_blanking();
    bcd_in = 16'h0070;
    dp_in  = 4'b0100;
    blank_lz = 1'b1;
    bcd_valid = 1'b1;
    for (int i = 0; i < 3 * FR; i++) begin
      step();
      bcd_valid = 1'b0;
      if (i == 2 * FR) blank_lz = 1'b0;
      checks++;
      if (got_h !== exp_h || got_l !== exp_l) begin
        failures++;
        $display("FAIL blanking e=%0d hi=%h/%h lo=%h/%h",
                 e, got_h, exp_h, got_l, exp_l);
      end
    end
  endtask

  task automatic test_dash();
    bcd_in = 16'h00AF;
    dp_in  = 4'b0001;
    bcd_valid = 1'b1;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      bcd_valid = 1'b0;
      checks++;
      if (got_h !== exp_h || got_l !== exp_l) begin
        failures++;
        $display("FAIL dash e=%0d hi=%h/%h lo=%h/%h",
                 e, got_h, exp_h, got_l, exp_l);
      end
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < FR + 2; i++) begin
      if (is_wrap(e + 1)) break;
      step();
    end
    bcd_in = 16'h9999;
    dp_in  = 4'b0000;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
    checks++;
    if (seg_h !== 7'h6F || seg_l !== 7'h10 || fd_h !== 1'b1) begin
      failures++;
      $display("FAIL bypass_now seg_h=%h seg_l=%h fd=%b want 6f/10/1",
               seg_h, seg_l, fd_h);
    end
    bcd_in = 16'h5555;
    bcd_valid = 1'b1;
    for (int i = 0; i < 2 * FR; i++) begin
      step();
      bcd_valid = 1'b0;
      checks++;
      if (got_h !== exp_h || got_l !== exp_l) begin
        failures++;
        $display("FAIL bypass e=%0d hi=%h/%h lo=%h/%h",
                 e, got_h, exp_h, got_l, exp_l);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bcd_valid = ($urandom_range(0, 5) == 0);
      bcd_in    = 16'($urandom);
      dp_in     = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bcd_in[15:8] = 8'h00;
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      step();
      checks++;
      if (got_h !== exp_h || got_l !== exp_l) begin
        failures++;
        $display("FAIL random e=%0d hi=%h/%h lo=%h/%h",
                 e, got_h, exp_h, got_l, exp_l);
      end
    end
    bcd_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    run_to(9);
    bcd_in = 16'h4321;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (got_h !== 13'h0 || got_l !== 13'h0FFF) begin
      failures++;
      $display("FAIL reset_mid hi=%h lo=%h want 0000/0fff", got_h, got_l);
    end
    rst = 1'b0;
    blank_lz = 1'b0;
    for (int i = 0; i < 2 * FR + DIV; i++) begin
      step();
      checks++;
      if (got_h !== exp_h || got_l !== exp_l) begin
        failures++;
        $display("FAIL after_reset e=%0d hi=%h/%h lo=%h/%h",
                 e, got_h, exp_h, got_l, exp_l);
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_blanking();
    test_dash();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
